// File: rtl/cpu_types_pkg.sv
// Shared pipeline types for the forwarding scoreboard: register index,
// scoreboard entry layout and the forward-select encodings for DEPTH=3.
package cpu_types_pkg;

    localparam int NREG = 32;
    localparam int REGW = $clog2(NREG);

    typedef logic [REGW-1:0] regbits_t;

    typedef struct packed {
        logic     valid;
        regbits_t wsel;
        logic     is_load;
    } sb_entry_t;

    // Forward-select values seen by EX with the default three tracked stages
    localparam int FWD_RF  = 0;
    localparam int FWD_MEM = 2;
    localparam int FWD_WB  = 3;

endpackage

// File: rtl/fwd_lookup.sv
// Youngest-producer search for one source operand: returns the stage the
// producer will occupy when the consumer reaches EX, or a load-use hazard.
module fwd_lookup #(
    parameter int REGW       = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 3,
    parameter int SELW       = $clog2(DEPTH + 1)
) (
    input  logic                      used,
    input  logic [REGW-1:0]           rs,
    input  logic [DEPTH:1]            ent_valid,
    input  logic [DEPTH:1][REGW-1:0]  ent_wsel,
    input  logic [DEPTH:1]            ent_load,
    output logic [SELW-1:0]           hit_sel,
    output logic                      hazard
);

    // Scan oldest to youngest so the youngest match is the last one written.
    // NOTE: every output gets a default before the loop, so no latch is inferred.
    always_comb begin
        hit_sel = '0;
        hazard  = 1'b0;
        if (used && rs != '0) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                if (ent_valid[k] && ent_wsel[k] != '0 && ent_wsel[k] == rs) begin
                    hit_sel = SELW'(k + 1);
                    hazard  = ent_load[k] && (k + 1 < LOAD_READY);
                end
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding and hazard scoreboard: shifts in-flight writes alongside EX..WB,
// registers the per-operand forward select into EX and counts hazard stalls.
module fwd_scoreboard
    import cpu_types_pkg::*;
#(
    parameter int NREG       = 32,
    parameter int REGW       = $clog2(NREG),
    parameter int DEPTH      = 3,
    parameter int NSRC       = 2,
    parameter int LOAD_READY = 3,
    parameter int SELW       = $clog2(DEPTH + 1),
    parameter int CNTW       = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 id_valid,
    input  logic [NSRC*REGW-1:0] id_rs,
    input  logic [NSRC-1:0]      id_rs_used,
    input  logic                 id_wen,
    input  logic [REGW-1:0]      id_wsel,
    input  logic                 id_is_load,
    input  logic                 mem_wait,
    input  logic                 flush,
    output logic                 stall,
    output logic [NSRC*SELW-1:0] ex_fwd_sel,
    output logic [CNTW-1:0]      stall_cnt
);

    typedef struct packed {
        logic            valid;
        logic [REGW-1:0] wsel;
        logic            is_load;
    } entry_t;

    localparam logic [SELW-1:0] SEL_RF = SELW'(FWD_RF);

    entry_t ent [1:DEPTH];

    logic [DEPTH:1]              ent_valid;
    logic [DEPTH:1][REGW-1:0]    ent_wsel;
    logic [DEPTH:1]              ent_load;
    logic [NSRC-1:0]             op_hazard;
    logic [NSRC-1:0][SELW-1:0]   sel_next;
    logic                        hazard;
    logic                        issue;

    always_comb begin
        ent_valid = '0;
        ent_wsel  = '0;
        ent_load  = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            ent_valid[k] = ent[k].valid;
            ent_wsel[k]  = ent[k].wsel;
            ent_load[k]  = ent[k].is_load;
        end
    end

    for (genvar i = 0; i < NSRC; i++) begin : g_lookup
        fwd_lookup #(
            .REGW       (REGW),
            .DEPTH      (DEPTH),
            .LOAD_READY (LOAD_READY),
            .SELW       (SELW)
        ) u_lookup (
            .used      (id_rs_used[i]),
            .rs        (id_rs[i*REGW +: REGW]),
            .ent_valid (ent_valid),
            .ent_wsel  (ent_wsel),
            .ent_load  (ent_load),
            .hit_sel   (sel_next[i]),
            .hazard    (op_hazard[i])
        );
    end

    assign hazard = id_valid && (|op_hazard);
    assign issue  = id_valid && !hazard && !flush;
    assign stall  = hazard || mem_wait;

    // A flushed or stalled slot enters as a bubble; mem_wait freezes everything.
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 1; k <= DEPTH; k++) begin
                ent[k] <= '0;
            end
            ex_fwd_sel <= {NSRC{SEL_RF}};
            stall_cnt  <= '0;
        end else if (!mem_wait) begin
            for (int k = 2; k <= DEPTH; k++) begin
                ent[k] <= ent[k-1];
            end
            if (issue && id_wen) begin
                ent[1] <= '{valid: 1'b1, wsel: id_wsel, is_load: id_is_load};
            end else begin
                ent[1] <= '0;
            end
            ex_fwd_sel <= issue ? sel_next : {NSRC{SEL_RF}};
            if (hazard && !flush && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed instruction stream with
// hand-computed forward selects checked by a queue-based monitor.
module tb_fwd_scoreboard;
    import cpu_types_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [9:0] id_rs = '0;
    logic [1:0] id_rs_used = '0;
    logic       id_wen = 1'b0;
    regbits_t   id_wsel = '0;
    logic       id_is_load = 1'b0;
    logic       mem_wait = 1'b0;
    logic       flush = 1'b0;
    logic       stall;
    logic [3:0] ex_fwd_sel;
    logic [15:0] stall_cnt;

    // Second instance with a narrow counter to reach saturation quickly
    logic       s_valid = 1'b0;
    logic [9:0] s_rs = '0;
    logic [1:0] s_used = '0;
    logic       s_wen = 1'b0;
    regbits_t   s_wsel = '0;
    logic       s_ld = 1'b0;
    logic       s_stall;
    logic [3:0] s_sel;
    logic [2:0] s_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] exp_q [$];
    logic mon_acc;

    always #5 clk = ~clk;

    fwd_scoreboard u_dut (
        .CLK(clk), .RST(rst), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .id_wen(id_wen), .id_wsel(id_wsel),
        .id_is_load(id_is_load), .mem_wait(mem_wait), .flush(flush),
        .stall(stall), .ex_fwd_sel(ex_fwd_sel), .stall_cnt(stall_cnt)
    );

    fwd_scoreboard #(.CNTW(3)) u_sat (
        .CLK(clk), .RST(rst), .id_valid(s_valid), .id_rs(s_rs),
        .id_rs_used(s_used), .id_wen(s_wen), .id_wsel(s_wsel),
        .id_is_load(s_ld), .mem_wait(1'b0), .flush(1'b0),
        .stall(s_stall), .ex_fwd_sel(s_sel), .stall_cnt(s_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sel2(input int e0, input int e1);
        return 32'({e1[1:0], e0[1:0]});
    endfunction

    // One decode cycle: drive at the falling edge, check the combinational stall,
    // and queue the expected EX select when the instruction is expected to issue.
    task automatic step(input string name, input logic v, input logic [4:0] r0,
                        input logic [4:0] r1, input logic [1:0] used, input logic wen,
                        input logic [4:0] wd, input logic ld, input logic mw,
                        input logic fl, input logic exp_stall, input int e0, input int e1);
        @(negedge clk);
        id_valid = v; id_rs = {r1, r0}; id_rs_used = used; id_wen = wen;
        id_wsel = wd; id_is_load = ld; mem_wait = mw; flush = fl;
        #1;
        check({name, " stall"}, 32'(stall), 32'(exp_stall));
        if (v && !exp_stall && !fl && !mw) exp_q.push_back(sel2(e0, e1)[3:0]);
    endtask

    // Monitor: an instruction leaving decode must show its select in the next cycle
    initial forever begin
        @(posedge clk);
        mon_acc = id_valid && !stall && !flush && !mem_wait && !rst;
        #1;
        if (mon_acc) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL monitor: instruction issued with no expected select queued");
            end else begin
                check("ex_fwd_sel", 32'(ex_fwd_sel), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        @(negedge clk); #1;
        check("reset stall", 32'(stall), 0);
        check("reset ex_fwd_sel", 32'(ex_fwd_sel), 0);
        check("reset stall_cnt", 32'(stall_cnt), 0);
        rst = 1'b0;

        //    name      v  rs0 rs1 used wen wd ld mw fl st e0 e1
        step("c1",  1, 1,  2,  2'b11, 1, 3,  0, 0, 0, 0, 0, 0);
        step("c2",  1, 3,  4,  2'b11, 1, 8,  0, 0, 0, 0, FWD_MEM, 0);
        step("c3",  1, 0,  0,  2'b00, 0, 0,  0, 0, 0, 0, 0, 0);
        step("c4",  1, 0,  0,  2'b00, 1, 10, 0, 0, 0, 0, 0, 0);
        step("c5",  1, 0,  0,  2'b00, 1, 11, 0, 0, 0, 0, 0, 0);
        step("c6",  1, 10, 11, 2'b11, 0, 0,  0, 0, 0, 0, FWD_WB, FWD_MEM);
        step("c7",  1, 10, 11, 2'b11, 0, 0,  0, 0, 0, 0, FWD_RF, FWD_WB);
        // Load-use: one bubble, then the load forwards from WB
        step("c8",  1, 0,  0,  2'b00, 1, 5,  1, 0, 0, 0, 0, 0);
        step("c9",  1, 6,  5,  2'b11, 1, 9,  0, 0, 0, 1, 0, 0);
        check("cnt before load-use edge", 32'(stall_cnt), 0);
        step("c10", 1, 6,  5,  2'b11, 1, 9,  0, 0, 0, 0, 0, FWD_WB);
        check("cnt after load-use", 32'(stall_cnt), 1);
        // Youngest producer wins; r0 writes and unused operands never forward
        step("c11", 1, 0,  0,  2'b00, 1, 7,  0, 0, 0, 0, 0, 0);
        step("c12", 1, 0,  0,  2'b00, 1, 7,  0, 0, 0, 0, 0, 0);
        step("c13", 1, 7,  7,  2'b01, 1, 0,  1, 0, 0, 0, FWD_MEM, 0);
        step("c14", 1, 0,  7,  2'b11, 0, 0,  0, 0, 0, 0, 0, FWD_WB);
        step("c15", 1, 0,  0,  2'b00, 1, 12, 1, 0, 0, 0, 0, 0);
        step("c16", 1, 12, 12, 2'b00, 1, 13, 0, 0, 0, 0, 0, 0);
        step("c17", 1, 13, 12, 2'b11, 1, 14, 1, 0, 0, 0, FWD_MEM, FWD_WB);
        // Memory wait with a pending load-use: everything frozen
        for (int i = 0; i < 4; i++) begin
            step("mw", 1, 14, 13, 2'b11, 0, 0, 0, 1, 0, 1, 0, 0);
            check("mw hold sel", 32'(ex_fwd_sel), sel2(FWD_MEM, FWD_WB));
            check("mw hold cnt", 32'(stall_cnt), 1);
        end
        step("c22", 1, 14, 13, 2'b11, 1, 15, 0, 0, 0, 1, 0, 0);
        check("post-mw hold sel", 32'(ex_fwd_sel), sel2(FWD_MEM, FWD_WB));
        step("c23", 1, 14, 13, 2'b11, 1, 15, 0, 0, 0, 0, FWD_WB, FWD_RF);
        check("bubble sel", 32'(ex_fwd_sel), 0);
        check("cnt after mw", 32'(stall_cnt), 2);
        // Load-use coincident with flush: bubble, no count, no stale producer
        step("c24", 1, 0,  0,  2'b00, 1, 16, 1, 0, 0, 0, 0, 0);
        step("c25", 1, 16, 0,  2'b01, 1, 20, 0, 0, 1, 1, 0, 0);
        step("c26", 1, 20, 16, 2'b11, 0, 0,  0, 0, 0, 0, FWD_RF, FWD_WB);
        check("flush bubble sel", 32'(ex_fwd_sel), 0);
        check("flush cnt", 32'(stall_cnt), 2);
        step("c27", 1, 0,  0,  2'b00, 1, 21, 0, 0, 1, 0, 0, 0);
        step("c28", 1, 21, 0,  2'b01, 1, 23, 0, 0, 0, 0, FWD_RF, 0);
        check("flushed slot sel", 32'(ex_fwd_sel), 0);
        step("c29", 1, 23, 0,  2'b01, 1, 22, 1, 0, 0, 0, FWD_MEM, 0);
        // Reset asserted in the middle of a load-use stall
        step("c30", 1, 22, 0,  2'b01, 0, 0,  0, 0, 0, 1, 0, 0);
        check("pre-reset sel", 32'(ex_fwd_sel), sel2(FWD_MEM, 0));
        #1 rst = 1'b1;
        #1;
        check("mid-reset stall", 32'(stall), 0);
        check("mid-reset sel", 32'(ex_fwd_sel), 0);
        check("mid-reset cnt", 32'(stall_cnt), 0);
        id_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step("c31", 1, 22, 0,  2'b01, 0, 0,  0, 0, 0, 0, FWD_RF, 0);
        step("idle", 0, 0, 0,  2'b00, 0, 0,  0, 0, 0, 0, 0, 0);
        step("idle", 0, 0, 0,  2'b00, 0, 0,  0, 0, 0, 0, 0, 0);
        check("post-reset cnt", 32'(stall_cnt), 0);
        check("expected queue drained", 32'(exp_q.size()), 0);

        // Saturation on a 3-bit counter: ten load-use hazards, count sticks at 7
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            s_valid = 1'b1; s_rs = '0; s_used = 2'b00; s_wen = 1'b1; s_wsel = 5'd5; s_ld = 1'b1;
            @(negedge clk);
            s_rs = {5'd0, 5'd5}; s_used = 2'b01; s_wen = 1'b0; s_ld = 1'b0;
            #1 check("sat hazard stall", 32'(s_stall), 1);
            @(negedge clk);
            #1 check("sat count", 32'(s_cnt), (i + 1 > 7) ? 7 : i + 1);
        end
        s_valid = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised forwarding and hazard scoreboard that replaces the per-stage combinational forward unit. It tracks every in-flight register write in a DEPTH-entry shift pipeline that mirrors EX..WB. For each of NSRC source operands of the instruction in decode, it resolves the youngest matching producer, registers the forward select into EX, and inserts load-use bubbles. It also freezes on memory wait, squashes on flush and counts hazard stalls.

## Interface
- NREG, 32: architectural registers; register 0 is hard zero.
- REGW, $clog2(NREG): register index width.
- DEPTH, 3: tracked post-decode stages; stage 1 = EX, 2 = MEM, 3 = WB.
- NSRC, 2: source operands per instruction.
- LOAD_READY, 3: lowest stage whose output can forward load data.
- SELW, $clog2(DEPTH+1): forward-select width.
- CNTW, 16: stall counter width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- id_valid  in  1  decode holds a real instruction.
- id_rs  in  NSRC*REGW  source register indices; operand i is at [i*REGW +: REGW].
- id_rs_used  in  NSRC  operand i is actually read.
- id_wen  in  1  decode instruction writes a register.
- id_wsel  in  REGW  destination register.
- id_is_load  in  1  decode instruction is a load.
- mem_wait  in  1  data memory not ready; whole pipeline frozen.
- flush  in  1  branch/jump squash of the decode instruction.
- stall  out  1  hold PC and IF/ID; comb = hazard | mem_wait.
- ex_fwd_sel  out  NSRC*SELW  registered per-operand select for EX: 0 = register file, k = stage-k output.
- stall_cnt  out  CNTW  saturating count of hazard-stall cycles.

## Operation
- Each entry holds {valid, wsel, is_load}. An entry counts as a producer only if valid=1 and wsel != 0. Entries are stored only for id_wen=1; otherwise valid=0.
- Lookup per operand i, skipped (sel 0, no hazard) if id_rs_used[i]=0 or rs=0:
  - Scan entries 1..DEPTH-1, youngest first. The first match at entry k wins.
  - Match with is_load=1 and k+1 < LOAD_READY: hazard.
  - Otherwise sel_next = k+1, the stage the producer will occupy when the consumer reaches EX.
  - No match, or only entry DEPTH matches: sel_next = 0 (regfile write-then-read covers it).
- hazard = OR over operands, gated by id_valid.
- Advance: when mem_wait=0, shift entries up by one and drop entry DEPTH. Entry 1 loads:
  - the decode instruction if id_valid & !hazard & !flush;
  - otherwise a bubble (valid=0).
- ex_fwd_sel advance:
  - loads sel_next when the decode instruction enters;
  - loads 0 on a bubble;
  - holds on mem_wait.
- mem_wait dominates: all entries, ex_fwd_sel and stall_cnt hold. stall=1 regardless of hazard.
- flush with hazard: a bubble is inserted and stall_cnt does not increment. Decode is squashed by the fetch logic.
- stall_cnt increments when hazard & !mem_wait & !flush, and saturates at all-ones.

## Timing
- Reset (async, immediate): all entries valid=0, ex_fwd_sel=0, stall_cnt=0; hence stall=0.
- Lookup and stall are combinational from entries and decode inputs, within the same cycle.
- ex_fwd_sel is valid the cycle after the consumer leaves decode, which is the consumer's EX cycle.
- A load-use pair separated by 0 instructions gets exactly 1 bubble with default LOAD_READY=3.
- RST asserted mid-stall clears all state; the next cycle's decode sees no producers.

## Structure
- cpu_types_pkg adds:
  - regbits_t sized by REGW;
  - sb_entry_t struct {valid, wsel, is_load};
  - fwd_sel constants FWD_RF=0, FWD_MEM=2, FWD_WB=3 for default DEPTH.
- Sub-module fwd_lookup: combinational per-operand youngest-match search returning {hit_sel, hazard}, instantiated NSRC times via generate.
- Top holds the entry shift register, the ex_fwd_sel register and the counter.

## Test plan
- Back-to-back ALU dependency (add r3; sub uses r3 as rs): no stall, ex_fwd_sel operand0=2 in the sub's EX cycle. One intervening instruction gives 3. Two intervening give 0.
- Load r5 then immediate add using r5 as rt: stall=1 for one cycle, stall_cnt 0->1. Operand1 select is 3 when the add reaches EX.
- Producers r7 in both entries 1 and 2 with consumer reading r7: youngest wins, select=2. Writes to r0 and id_rs_used=0 operands never forward or stall.
- mem_wait high for 4 cycles mid-sequence: stall=1 throughout, ex_fwd_sel and stall_cnt unchanged. Forwarding resumes correctly after release.
- Load-use hazard coincident with flush: bubble inserted, stall_cnt unchanged. Next decode instruction sees no spurious producer.
- Force stall_cnt to 16'hFFFE, then apply 3 hazard cycles: it reads FFFF and holds. Assert RST mid-stall: all outputs 0 immediately.
